bus_controller: RTL and testbench

//  Sits directly downstream of the CPU core's r/w/address/data strobes and owns the

---
 rtl/bus_controller.sv | 197 +++++++++++++++++++
 tb/tb_bus_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bus_controller.sv
// -----------------------------------------------------------------------------
// bus_controller
//
// Owns the physical memory bus on behalf of the CPU core. Each CPU access is
// decoded into a RAM, ROM or IO chip select. The strobes are held for the
// per-region number of wait states. Read data goes back to the CPU together
// with a one-cycle cpu_ready pulse, and illegal requests raise a sticky
// bus_fault flag.
//
// Address map:  RAM 0x0000..ROM_BASE-1, ROM ROM_BASE..IO_BASE-1, IO IO_BASE..0xFFFF
//
// Optional feature (compile-time macro ROM_WP_EN):
//   defined   - ROM is write protected. A ROM write asserts rom_cs but never
//               mem_we, sets bus_fault, and still completes with ROM timing.
//   undefined - ROM writes behave like RAM writes.
//
// Ports:
//   clk        in   1   system clock, all state on posedge
//   reset      in   1   asynchronous active-low reset
//   cpu_addr   in  16   CPU address, sampled at request
//   cpu_wdata  in   8   CPU write data, sampled at request
//   cpu_r      in   1   read request (level, sampled in IDLE)
//   cpu_w      in   1   write request (level, sampled in IDLE)
//   cpu_rdata  out  8   read data, held until the next read completes
//   cpu_ready  out  1   one-cycle pulse, access complete
//   mem_addr   out 16   latched address
//   mem_wdata  out  8   latched write data
//   mem_rdata  in   8   data from the selected device
//   ram_cs     out  1   RAM chip select
//   rom_cs     out  1   ROM chip select
//   io_cs      out  1   IO chip select
//   mem_oe     out  1   read strobe
//   mem_we     out  1   write strobe
//   bus_fault  out  1   sticky fault flag, cleared only by reset
//
// States:
//   IDLE   | waiting for a request; accepts exactly one of cpu_r / cpu_w
//   ACCESS | strobes held while the wait counter runs down to zero
//   DONE   | cpu_ready pulses for one cycle, then back to IDLE
// -----------------------------------------------------------------------------
module bus_controller #(
    parameter logic [15:0] ROM_BASE = 16'h2000,
    parameter logic [15:0] IO_BASE  = 16'hF000,
    parameter logic [3:0]  RAM_WAIT = 4'd0,
    parameter logic [3:0]  ROM_WAIT = 4'd1,
    parameter logic [3:0]  IO_WAIT  = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_r,
    input  logic        cpu_w,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        ram_cs,
    output logic        rom_cs,
    output logic        io_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic        bus_fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic [15:0] mem_addr_nxt;
    logic [7:0]  mem_wdata_nxt;
    logic [7:0]  cpu_rdata_nxt;
    logic        ram_cs_nxt, rom_cs_nxt, io_cs_nxt;
    logic        mem_oe_nxt, mem_we_nxt;
    logic        bus_fault_nxt;

    logic        sel_ram, sel_rom, sel_io;
    logic [3:0]  sel_wait;

    // Region decode of the live CPU address; only used when a request is taken.
    always_comb begin
        sel_ram  = (cpu_addr < ROM_BASE);
        sel_io   = (cpu_addr >= IO_BASE);
        sel_rom  = !sel_ram && !sel_io;
        sel_wait = sel_ram ? RAM_WAIT : (sel_rom ? ROM_WAIT : IO_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        cpu_rdata_nxt = cpu_rdata;
        ram_cs_nxt    = ram_cs;
        rom_cs_nxt    = rom_cs;
        io_cs_nxt     = io_cs;
        mem_oe_nxt    = mem_oe;
        mem_we_nxt    = mem_we;
        bus_fault_nxt = bus_fault;
        cpu_ready     = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_r && cpu_w) begin
                    // Conflicting request: run one empty ACCESS cycle without
                    // strobes, so the CPU sees the same latency as a
                    // zero-wait access.
                    bus_fault_nxt = 1'b1;
                    wait_cnt_nxt  = 4'd0;
                    state_nxt     = ACCESS;
                end else if (cpu_r || cpu_w) begin
                    mem_addr_nxt  = cpu_addr;
                    mem_wdata_nxt = cpu_wdata;
                    ram_cs_nxt    = sel_ram;
                    rom_cs_nxt    = sel_rom;
                    io_cs_nxt     = sel_io;
                    mem_oe_nxt    = cpu_r;
                    mem_we_nxt    = cpu_w;
`ifdef ROM_WP_EN
                    if (cpu_w && sel_rom) begin
                        mem_we_nxt    = 1'b0;
                        bus_fault_nxt = 1'b1;
                    end
`endif
                    wait_cnt_nxt  = sel_wait;
                    state_nxt     = ACCESS;
                end
            end

            ACCESS: begin
                if (wait_cnt != 4'd0) begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end else begin
                    // mem_oe is high only for reads, so it qualifies the capture.
                    if (mem_oe) begin
                        cpu_rdata_nxt = mem_rdata;
                    end
                    ram_cs_nxt = 1'b0;
                    rom_cs_nxt = 1'b0;
                    io_cs_nxt  = 1'b0;
                    mem_oe_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    state_nxt  = DONE;
                end
            end

            DONE: begin
                cpu_ready = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
            cpu_rdata <= 8'h00;
            ram_cs    <= 1'b0;
            rom_cs    <= 1'b0;
            io_cs     <= 1'b0;
            mem_oe    <= 1'b0;
            mem_we    <= 1'b0;
            bus_fault <= 1'b0;
        end else begin
            wait_cnt  <= wait_cnt_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            ram_cs    <= ram_cs_nxt;
            rom_cs    <= rom_cs_nxt;
            io_cs     <= io_cs_nxt;
            mem_oe    <= mem_oe_nxt;
            mem_we    <= mem_we_nxt;
            bus_fault <= bus_fault_nxt;
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
module tb_bus_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_r;
    logic        cpu_w;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        ram_cs;
    logic        rom_cs;
    logic        io_cs;
    logic        mem_oe;
    logic        mem_we;
    logic        bus_fault;

    int checks = 0;
    int passed = 0;

`ifdef ROM_WP_EN
    localparam int   ROMW_WE    = 0;
    localparam logic ROMW_FAULT = 1'b1;
`else
    localparam int   ROMW_WE    = 2;
    localparam logic ROMW_FAULT = 1'b0;
`endif

    bus_controller dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_r     (cpu_r),
        .cpu_w     (cpu_w),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ram_cs    (ram_cs),
        .rom_cs    (rom_cs),
        .io_cs     (io_cs),
        .mem_oe    (mem_oe),
        .mem_we    (mem_we),
        .bus_fault (bus_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        w;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdin;
        int          ram_n;
        int          rom_n;
        int          io_n;
        int          oe_n;
        int          we_n;
        int          lat;
        logic [7:0]  rdata;
        logic        fault;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wdata;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one request, count strobe cycles until cpu_ready, check results.
    // Samples are taken on the falling edge; period n lies between the
    // request edge T+n-1 and T+n, so ready seen in period n means latency n.
    task automatic run_vec(input vec_t v, input string name);
        int ram_n = 0, rom_n = 0, io_n = 0, oe_n = 0, we_n = 0, lat = 0;
        @(negedge clk);
        cpu_addr  = v.addr;
        cpu_wdata = v.wdata;
        cpu_r     = v.r;
        cpu_w     = v.w;
        mem_rdata = v.rdin;
        @(negedge clk);
        cpu_r     = 1'b0;
        cpu_w     = 1'b0;
        cpu_addr  = 16'hAAAA;
        cpu_wdata = 8'hFF;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            ram_n += int'(ram_cs);
            rom_n += int'(rom_cs);
            io_n  += int'(io_cs);
            oe_n  += int'(mem_oe);
            we_n  += int'(mem_we);
            if (cpu_ready) lat = n;
            else @(negedge clk);
        end
        chk({name, " latency"}, lat, v.lat);
        chk({name, " ram_cs cycles"}, ram_n, v.ram_n);
        chk({name, " rom_cs cycles"}, rom_n, v.rom_n);
        chk({name, " io_cs cycles"}, io_n, v.io_n);
        chk({name, " mem_oe cycles"}, oe_n, v.oe_n);
        chk({name, " mem_we cycles"}, we_n, v.we_n);
        @(negedge clk);
        chk({name, " ready one cycle"}, int'(cpu_ready), 0);
        chk({name, " cpu_rdata"}, int'(cpu_rdata), int'(v.rdata));
        chk({name, " bus_fault"}, int'(bus_fault), int'(v.fault));
        chk({name, " mem_addr held"}, int'(mem_addr), int'(v.exp_addr));
        chk({name, " mem_wdata held"}, int'(mem_wdata), int'(v.exp_wdata));
    endtask

    initial begin
        vec_t v;

        //        r  w  addr      wdata  rdin  ram rom io oe we lat  rdata  flt addr      wdata
        vecs[0] = '{1, 0, 16'h1C00, 8'h00, 8'hA5, 1, 0, 0, 1, 0, 2, 8'hA5, 1'b0, 16'h1C00, 8'h00};
        vecs[1] = '{1, 0, 16'h2000, 8'h00, 8'h3C, 0, 2, 0, 2, 0, 3, 8'h3C, 1'b0, 16'h2000, 8'h00};
        vecs[2] = '{0, 1, 16'hF000, 8'h5A, 8'h00, 0, 0, 3, 0, 3, 4, 8'h3C, 1'b0, 16'hF000, 8'h5A};
        vecs[3] = '{1, 0, 16'h1FFF, 8'h00, 8'h11, 1, 0, 0, 1, 0, 2, 8'h11, 1'b0, 16'h1FFF, 8'h00};
        vecs[4] = '{1, 0, 16'hEFFF, 8'h00, 8'h22, 0, 2, 0, 2, 0, 3, 8'h22, 1'b0, 16'hEFFF, 8'h00};
        vecs[5] = '{1, 0, 16'hFFFF, 8'h00, 8'h33, 0, 0, 3, 3, 0, 4, 8'h33, 1'b0, 16'hFFFF, 8'h00};
        vecs[6] = '{0, 1, 16'h0000, 8'h44, 8'h00, 1, 0, 0, 0, 1, 2, 8'h33, 1'b0, 16'h0000, 8'h44};
        vecs[7] = '{0, 1, 16'h2FFF, 8'h66, 8'h00, 0, 2, 0, 0, ROMW_WE, 3, 8'h33, ROMW_FAULT, 16'h2FFF, 8'h66};
        vecs[8] = '{1, 1, 16'h0010, 8'h77, 8'h88, 0, 0, 0, 0, 0, 2, 8'h33, 1'b1, 16'h2FFF, 8'h66};

        reset     = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        cpu_r     = 1'b0;
        cpu_w     = 1'b0;
        mem_rdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset cpu_ready", int'(cpu_ready), 0);
        chk("reset strobes", int'({ram_cs, rom_cs, io_cs, mem_oe, mem_we}), 0);
        chk("reset bus_fault", int'(bus_fault), 0);
        chk("reset cpu_rdata", int'(cpu_rdata), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Async reset in the middle of an IO read wait.
        @(negedge clk);
        cpu_addr  = 16'hF100;
        cpu_r     = 1'b1;
        mem_rdata = 8'h77;
        @(negedge clk);
        cpu_r = 1'b0;
        #2;
        chk("abort io_cs before reset", int'(io_cs), 1);
        reset = 1'b0;
        #1;
        chk("abort strobes", int'({ram_cs, rom_cs, io_cs, mem_oe, mem_we}), 0);
        chk("abort bus_fault", int'(bus_fault), 0);
        chk("abort cpu_rdata", int'(cpu_rdata), 0);
        chk("abort mem_addr", int'(mem_addr), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort no ready", int'(cpu_ready), 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post-reset idle no ready", int'(cpu_ready), 0);
        end

        v = '{1, 0, 16'h1FFF, 8'h00, 8'h99, 1, 0, 0, 1, 0, 2, 8'h99, 1'b0, 16'h1FFF, 8'h00};
        run_vec(v, "post-reset read");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
